// File: rtl/synth_pkg.sv
// synth_pkg: register map, reset defaults and saturation helper shared by the mixer.
package synth_pkg;
  localparam logic [3:0] LVL = 4'd2;
  localparam logic [3:0] PAN = 4'd7;
  localparam logic [3:0] MUTE = 4'd8;
  localparam logic [6:0] MVOL = 7'd1;
  localparam logic [7:0] LVL_RST_LO = 8'h40;
  localparam logic [7:0] LVL_RST_HI = 8'h00;
  localparam logic [7:0] PAN_RST = 8'h40;
  localparam logic [7:0] MVOL_RST = 8'h40;
  // Clamp v into the signed range of a w-bit word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    return (v > hi) ? hi : ((v < -hi - 64'sd1) ? -hi - 64'sd1 : v);
  endfunction
endpackage

// File: rtl/mixer_regs.sv
// mixer_regs: per-oscillator level/pan/mute and master volume registers.
module mixer_regs
  import synth_pkg::*;
#(
  parameter int V_OSC = 4
) (
  input  logic                  sCLK_XVXENVS,
  input  logic                  iRST_N,
  input  logic [7:0]            data,
  input  logic [6:0]            adr,
  input  logic                  write,
  input  logic                  osc_sel,
  input  logic                  com_sel,
  output logic [V_OSC-1:0][7:0] osc_lvl,
  output logic [V_OSC-1:0][7:0] osc_pan,
  output logic [V_OSC-1:0]      osc_mute,
  output logic [7:0]            m_vol
);
  logic [V_OSC-1:0][7:0] lvl_q, lvl_d, pan_q, pan_d;
  logic [V_OSC-1:0]      mute_q, mute_d;
  logic [7:0]            mvol_q, mvol_d;
  // osc_sel wins: a combined select never reaches the common bank.
  always_comb begin
    lvl_d = lvl_q;
    pan_d = pan_q;
    mute_d = mute_q;
    mvol_d = mvol_q;
    if (write && osc_sel) begin
      for (int o = 0; o < V_OSC; o++) begin
        if (adr[6:4] == 3'(o)) begin
          if (adr[3:0] == LVL) lvl_d[o] = data;
          if (adr[3:0] == PAN) pan_d[o] = data;
          if (adr[3:0] == MUTE) mute_d[o] = data[0];
        end
      end
    end else if (write && com_sel && adr == MVOL) mvol_d = data;
  end
  always_ff @(posedge sCLK_XVXENVS or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int o = 0; o < V_OSC; o++) begin
        lvl_q[o] <= (o < 2) ? LVL_RST_LO : LVL_RST_HI;
        pan_q[o] <= PAN_RST;
      end
      mute_q <= '0;
      mvol_q <= MVOL_RST;
    end else begin
      lvl_q <= lvl_d;
      pan_q <= pan_d;
      mute_q <= mute_d;
      mvol_q <= mvol_d;
    end
  end
  assign osc_lvl = lvl_q;
  assign osc_pan = pan_q;
  assign osc_mute = mute_q;
  assign m_vol = mvol_q;
endmodule

// File: rtl/mixer_3.sv
// mixer_3: four-stage scale/pan/accumulate pipeline producing one saturated stereo sample per frame.
module mixer_3
  import synth_pkg::*;
#(
  parameter int VOICES    = 8,
  parameter int V_OSC     = 4,
  parameter int SAMPLE_W  = 17,
  parameter int OUT_W     = 16,
  parameter int MIX_SHIFT = 5
) (
  input  logic                       sCLK_XVXENVS,
  input  logic                       iRST_N,
  input  logic                       in_valid,
  input  logic                       in_last,
  input  logic [$clog2(V_OSC)-1:0]   in_ox,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  input  logic signed [7:0]          in_osc_env,
  input  logic signed [7:0]          in_voice_env,
  input  logic [7:0]                 data,
  input  logic [6:0]                 adr,
  input  logic                       write,
  input  logic                       osc_sel,
  input  logic                       com_sel,
  output logic signed [OUT_W-1:0]    lsound_out,
  output logic signed [OUT_W-1:0]    rsound_out,
  output logic                       out_valid,
  output logic                       clip
);
  localparam int OX_W  = $clog2(V_OSC);
  localparam int ACC_W = SAMPLE_W + $clog2(VOICES * V_OSC) + 2;
  localparam int M1_W  = SAMPLE_W + 8;
  localparam int P1_W  = SAMPLE_W + 1;
  localparam int M2_W  = P1_W + 18;
  localparam int P2_W  = M2_W - 14;
  localparam int M3_W  = P2_W + 17;
  logic [V_OSC-1:0][7:0] osc_lvl, osc_pan;
  logic [V_OSC-1:0]      osc_mute;
  logic [7:0]            m_vol;
  mixer_regs #(.V_OSC(V_OSC)) u_regs (
    .sCLK_XVXENVS(sCLK_XVXENVS), .iRST_N(iRST_N), .data(data), .adr(adr), .write(write),
    .osc_sel(osc_sel), .com_sel(com_sel), .osc_lvl(osc_lvl), .osc_pan(osc_pan),
    .osc_mute(osc_mute), .m_vol(m_vol)
  );
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic last1_q, last1_d, last2_q, last2_d, last3_q, last3_d;
  logic [OX_W-1:0] ox1_q, ox1_d, ox2_q, ox2_d;
  logic signed [7:0] venv1_q, venv1_d, venv2_q, venv2_d;
  logic signed [P1_W-1:0] p1_q, p1_d;
  logic signed [P2_W-1:0] p2_q, p2_d;
  logic signed [ACC_W-1:0] pl_q, pl_d, pr_q, pr_d, acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic signed [OUT_W-1:0] lout_q, lout_d, rout_q, rout_d;
  logic ov_q, ov_d, clip_q, clip_d;
  logic signed [M1_W-1:0] m1;
  logic signed [M2_W-1:0] m2;
  logic signed [M3_W-1:0] ml, mr;
  logic signed [8:0] pan_s;
  logic signed [ACC_W-1:0] sum_l, sum_r;
  logic signed [63:0] sh_l, sh_r, sat_l, sat_r;
  logic fire;
  always_comb begin
    m1 = M1_W'(in_sample) * M1_W'(in_osc_env);
    m2 = M2_W'(p1_q) * M2_W'($signed({1'b0, osc_lvl[ox1_q]})) * M2_W'($signed({1'b0, m_vol}));
    pan_s = $signed({1'b0, osc_pan[ox2_q]});
    ml = M3_W'(p2_q) * M3_W'(venv2_q) * M3_W'(9'sd127 - pan_s);
    mr = M3_W'(p2_q) * M3_W'(venv2_q) * M3_W'(pan_s);
    v1_d = in_valid;
    last1_d = in_valid && in_last;
    ox1_d = in_ox;
    venv1_d = in_voice_env;
    p1_d = P1_W'(m1 >>> 7);
    v2_d = v1_q;
    last2_d = last1_q;
    ox2_d = ox1_q;
    venv2_d = venv1_q;
    p2_d = osc_mute[ox1_q] ? '0 : P2_W'(m2 >>> 14);
    v3_d = v2_q;
    last3_d = last2_q;
    pl_d = ACC_W'(ml >>> 14);
    pr_d = ACC_W'(mr >>> 14);
    // The closing item is folded into the result and the accumulator restarts from zero.
    fire = v3_q && last3_q;
    sum_l = acc_l_q + pl_q;
    sum_r = acc_r_q + pr_q;
    sh_l = 64'(sum_l >>> MIX_SHIFT);
    sh_r = 64'(sum_r >>> MIX_SHIFT);
    sat_l = saturate(sh_l, OUT_W);
    sat_r = saturate(sh_r, OUT_W);
    acc_l_d = !v3_q ? acc_l_q : (last3_q ? '0 : sum_l);
    acc_r_d = !v3_q ? acc_r_q : (last3_q ? '0 : sum_r);
    lout_d = fire ? OUT_W'(sat_l) : lout_q;
    rout_d = fire ? OUT_W'(sat_r) : rout_q;
    ov_d = fire;
    clip_d = fire && (sat_l != sh_l || sat_r != sh_r);
  end
  always_ff @(posedge sCLK_XVXENVS or negedge iRST_N) begin
    if (!iRST_N) begin
      {v1_q, v2_q, v3_q, last1_q, last2_q, last3_q} <= '0;
      {ox1_q, ox2_q, venv1_q, venv2_q} <= '0;
      {p1_q, p2_q, pl_q, pr_q, acc_l_q, acc_r_q} <= '0;
      {lout_q, rout_q, ov_q, clip_q} <= '0;
    end else begin
      {v1_q, v2_q, v3_q, last1_q, last2_q, last3_q} <= {v1_d, v2_d, v3_d, last1_d, last2_d, last3_d};
      {ox1_q, ox2_q, venv1_q, venv2_q} <= {ox1_d, ox2_d, venv1_d, venv2_d};
      {p1_q, p2_q, pl_q, pr_q, acc_l_q, acc_r_q} <= {p1_d, p2_d, pl_d, pr_d, acc_l_d, acc_r_d};
      {lout_q, rout_q, ov_q, clip_q} <= {lout_d, rout_d, ov_d, clip_d};
    end
  end
  assign lsound_out = lout_q;
  assign rsound_out = rout_q;
  assign out_valid = ov_q;
  assign clip = clip_q;
endmodule

// File: tb/tb_mixer_3.sv
// tb_mixer_3: vector table, directed register cases and random frames scored against an arithmetic model.
module tb_mixer_3;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0, in_last = 1'b0;
  logic [1:0] in_ox = '0;
  logic signed [16:0] in_sample = '0;
  logic signed [7:0] in_osc_env = '0, in_voice_env = '0;
  logic [7:0] data = '0;
  logic [6:0] adr = '0;
  logic write = 1'b0, osc_sel = 1'b0, com_sel = 1'b0;
  logic signed [15:0] lsound_out, rsound_out;
  logic out_valid, clip;
  mixer_3 dut (
    .sCLK_XVXENVS(clk), .iRST_N(rst_n), .in_valid(in_valid), .in_last(in_last), .in_ox(in_ox),
    .in_sample(in_sample), .in_osc_env(in_osc_env), .in_voice_env(in_voice_env), .data(data),
    .adr(adr), .write(write), .osc_sel(osc_sel), .com_sel(com_sel), .lsound_out(lsound_out),
    .rsound_out(rsound_out), .out_valid(out_valid), .clip(clip)
  );
  always #5 clk = ~clk;
  typedef struct { longint due, l, r; bit clip; } exp_t;
  typedef struct { longint s, oe, ve; int ox; longint l, r; } vec_t;
  exp_t q[$];
  exp_t e_sb;
  vec_t tv[4];
  int n_chk = 0, n_pass = 0;
  longint cyc = 0;
  longint sh_lvl[4], sh_pan[4], sh_mvol, acc_l, acc_r;
  bit sh_mute[4];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
  endtask
  function automatic longint clamp(longint x);
    return x > 32767 ? 32767 : (x < -32768 ? -32768 : x);
  endfunction
  task automatic reset_model;
    for (int o = 0; o < 4; o++) begin
      sh_lvl[o] = (o < 2) ? 64 : 0;
      sh_pan[o] = 64;
      sh_mute[o] = 0;
    end
    sh_mvol = 64;
    acc_l = 0;
    acc_r = 0;
    q.delete();
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(int n);
    repeat (n) tick;
  endtask
  task automatic drive(longint s, longint oe, longint ve, int ox, bit last);
    in_valid = 1; in_last = last; in_sample = 17'(s);
    in_osc_env = 8'(oe); in_voice_env = 8'(ve); in_ox = 2'(ox);
    tick;
    in_valid = 0; in_last = 0;
  endtask
  // Model: each contribution scaled by envelope, level, volume and pan; frame sum shifted and clamped.
  task automatic send(longint s, longint oe, longint ve, int ox, bit last);
    longint p1, p2, l, r;
    p1 = (s * oe) >>> 7;
    p2 = sh_mute[ox] ? 0 : (p1 * sh_lvl[ox] * sh_mvol) >>> 14;
    acc_l += (p2 * ve * (127 - sh_pan[ox])) >>> 14;
    acc_r += (p2 * ve * sh_pan[ox]) >>> 14;
    if (last) begin
      l = clamp(acc_l >>> 5);
      r = clamp(acc_r >>> 5);
      q.push_back('{cyc + 4, l, r, (l != (acc_l >>> 5)) || (r != (acc_r >>> 5))});
      acc_l = 0;
      acc_r = 0;
    end
    drive(s, oe, ve, ox, last);
  endtask
  task automatic wr_raw(bit os, bit cs, int a, int d);
    osc_sel = os; com_sel = cs; adr = 7'(a); data = 8'(d); write = 1;
    tick;
    write = 0; osc_sel = 0; com_sel = 0;
  endtask
  task automatic wr_osc(int o, int off, longint d);
    wr_raw(1, 0, off + 16 * o, int'(d));
    if (off == 2) sh_lvl[o] = d;
    if (off == 7) sh_pan[o] = d;
    if (off == 8) sh_mute[o] = d[0];
  endtask
  task automatic wr_mvol(longint d);
    wr_raw(0, 1, 1, int'(d));
    sh_mvol = d;
  endtask
  task automatic rand_frame(int n, bit bubbles);
    for (int i = 0; i < n; i++) begin
      if (bubbles && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      send(longint'($urandom_range(0, 131071)) - 65536, longint'($urandom_range(0, 255)) - 128,
           longint'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 3)), i == n - 1);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) chk("unexpected_pulse", out_valid, 0);
        else begin
          e_sb = q.pop_front();
          chk("pulse_cycle", cyc, e_sb.due);
          chk("lsound", lsound_out, e_sb.l);
          chk("rsound", rsound_out, e_sb.r);
          chk("clip", clip, e_sb.clip);
        end
      end else begin
        if (clip) chk("clip_without_valid", clip, 0);
        if (q.size() > 0 && q[0].due < cyc) begin
          chk("missing_pulse", out_valid, 1);
          void'(q.pop_front());
        end
      end
    end
  end
  initial begin
    tv[0] = '{65535, 127, 127, 0, 248, 252};
    tv[1] = '{-65536, 127, 127, 1, -249, -253};
    tv[2] = '{50000, 100, -100, 2, 0, 0};
    tv[3] = '{1000, -128, 127, 0, -4, -4};
    reset_model();
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_clip", clip, 0);
    chk("rst_l", lsound_out, 0);
    chk("rst_r", rsound_out, 0);
    rst_n = 1;
    tick;
    for (int i = 0; i < 4; i++) begin
      q.push_back('{cyc + 4, tv[i].l, tv[i].r, 1'b0});
      drive(tv[i].s, tv[i].oe, tv[i].ve, tv[i].ox, 1);
      idle(6);
      if (i == 0) chk("single_item_positive", lsound_out > 0 && rsound_out > 0, 1);
    end
    wr_osc(0, 7, 0);
    send(65535, 127, 127, 0, 1);
    idle(6);
    chk("pan0_r_zero", rsound_out, 0);
    chk("pan0_l_nonzero", lsound_out != 0, 1);
    wr_osc(1, 8, 1);
    send(40000, 100, 90, 1, 0);
    send(40000, 100, 90, 0, 1);
    idle(6);
    send(40000, 100, 90, 0, 1);
    idle(6);
    wr_raw(1, 1, 1, 0);
    wr_raw(1, 0, 3, 0);
    wr_raw(0, 1, 2, 0);
    send(-30000, 90, 110, 0, 1);
    idle(6);
    for (int o = 0; o < 4; o++) begin
      wr_osc(o, 2, 127);
      wr_osc(o, 7, 0);
      wr_osc(o, 8, 0);
    end
    wr_mvol(127);
    for (int i = 0; i < 32; i++) send(65535, 127, 127, i % 4, i == 31);
    idle(6);
    chk("full_scale_l", lsound_out, 32767);
    for (int i = 0; i < 32; i++) send(-65536, 127, 127, i % 4, i == 31);
    idle(6);
    chk("full_scale_neg_l", lsound_out, -32768);
    repeat (6) begin
      for (int o = 0; o < 4; o++) begin
        wr_osc(o, 2, $urandom_range(0, 127));
        wr_osc(o, 7, $urandom_range(0, 127));
        wr_osc(o, 8, $urandom_range(0, 3) == 0);
      end
      wr_mvol($urandom_range(0, 127));
      rand_frame($urandom_range(1, 8), 0);
      rand_frame($urandom_range(1, 8), 1);
      idle(6);
    end
    send(20000, 80, 80, 0, 0);
    send(20000, 80, 80, 1, 0);
    send(20000, 80, 80, 0, 0);
    rst_n = 0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_l", lsound_out, 0);
    chk("midrst_r", rsound_out, 0);
    reset_model();
    idle(2);
    rst_n = 1;
    tick;
    rand_frame(4, 0);
    idle(6);
    send(30000, 100, 100, 0, 1);
    idle(1);
    rst_n = 0;
    reset_model();
    idle(2);
    rst_n = 1;
    idle(8);
    rand_frame(3, 1);
    idle(6);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
